// File: rtl/src_frame_buf_if.sv
// Loader stream and lenet read/launch signals of the ping-pong source frame buffer.
// master = loader/lenet side, slave = src_frame_buf.
`timescale 1ns/1ps
interface src_frame_buf_if #(
  parameter int PIX_W = 8,
  parameter int IN_W  = 9,
  parameter int AW    = 10
);
  // Stream handshake: a beat transfers on a rising clk edge where wr_valid && wr_ready.
  // wr_ready depends only on buffer state, never on wr_valid; a beat offered while
  // wr_ready is low is not consumed and must be held until it transfers.
  logic             wr_valid;
  logic [IN_W-1:0]  wr_data;
  logic             wr_ready;
  logic             go;
  logic             done;
  logic             cena;
  logic [AW-1:0]    aa;
  logic [PIX_W-1:0] qa;

  modport master (output wr_valid, wr_data, done, cena, aa, input wr_ready, go, qa);
  modport slave  (input wr_valid, wr_data, done, cena, aa, output wr_ready, go, qa);
endinterface

// File: rtl/src_frame_buf.sv
// Ping-pong source frame buffer: one bank fills from the loader while lenet reads the other.
// Optional macro SRC_FRAME_BUF_SAT_EN saturates wide input pixels instead of truncating them.
`timescale 1ns/1ps
module src_frame_buf #(
  parameter int PIX_W   = 8,
  parameter int IN_W    = 9,
  parameter int FRAME_W = 32,
  parameter int FRAME_H = 32,
  parameter int AW      = $clog2(FRAME_W*FRAME_H)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          abort,
  src_frame_buf_if.slave bus,
  output logic [1:0]    bank_full,
  output logic [15:0]   frame_cnt,
  output logic [1:0]    state_dbg
);

  localparam int DEPTH   = FRAME_W*FRAME_H;
  localparam int PIX_MAX = (1 << PIX_W) - 1;

  typedef enum logic [1:0] {IDLE = 2'd0, GO = 2'd1, BUSY = 2'd2} state_t;

  state_t           state;
  logic             wb;
  logic             rb;
  logic [AW-1:0]    wcnt;
  logic             go_q;
  logic [PIX_W-1:0] qa_q;
  logic [PIX_W-1:0] pix_in;
  logic             wr_fire;
  logic             unused_hi;

  logic [PIX_W-1:0] mem [2][DEPTH];

  assign bus.wr_ready = !bank_full[wb];
  assign wr_fire      = bus.wr_valid && !bank_full[wb];
  assign bus.go       = go_q;
  assign bus.qa       = qa_q;
  assign state_dbg    = state;
  assign unused_hi    = ^bus.wr_data;

  always_comb begin
    pix_in = bus.wr_data[PIX_W-1:0];
`ifdef SRC_FRAME_BUF_SAT_EN
    if (bus.wr_data > IN_W'(PIX_MAX)) pix_in = PIX_W'(PIX_MAX);
`endif
  end

  // Write side and read FSM share one block because both edit bank_full;
  // a write fill and a read release always target different banks.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      go_q      <= 1'b0;
      wb        <= 1'b0;
      rb        <= 1'b0;
      wcnt      <= '0;
      bank_full <= 2'b00;
      frame_cnt <= 16'd0;
    end else if (abort) begin
      state     <= IDLE;
      go_q      <= 1'b0;
      wb        <= 1'b0;
      rb        <= 1'b0;
      wcnt      <= '0;
      bank_full <= 2'b00;
    end else begin
      if (wr_fire) begin
        if (wcnt == AW'(DEPTH-1)) begin
          wcnt          <= '0;
          bank_full[wb] <= 1'b1;
          wb            <= ~wb;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (bank_full[rb]) begin
            state <= GO;
            go_q  <= 1'b1;
          end
        end
        GO: begin
          state <= BUSY;
          go_q  <= 1'b0;
        end
        BUSY: begin
          if (bus.done) begin
            state         <= IDLE;
            bank_full[rb] <= 1'b0;
            rb            <= ~rb;
            frame_cnt     <= frame_cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          go_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire && !abort) mem[wb][wcnt] <= pix_in;
  end

  // Out-of-range addresses read as zero rather than aliasing into the bank.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      qa_q <= '0;
    end else if (!bus.cena) begin
      qa_q <= (32'(bus.aa) >= DEPTH) ? '0 : mem[rb][bus.aa];
    end
  end

endmodule
